sonar_medidor_hcsr04: RTL and testbench

Ultrasonic range-measurement front end. It sits directly upstream of the sonar control unit: on each one-cycle `medir` request it fires the HC-SR04 trigger, times the echo pulse, and converts the width to whole centimetres as three BCD digits ready for ASCII serialisation. Completion is signalled with a one-cycle `pronto` pulse, which the control unit consumes as `pronto_medida`.

---
 rtl/sonar_pkg.sv | 28 ++
 rtl/contador_cm_bcd.sv | 61 ++++++
 rtl/sonar_medidor_hcsr04.sv | 120 ++++++++++++
 tb/tb_sonar_medidor_hcsr04.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared state codes, BCD widths and default 50 MHz timing for the sonar blocks
package sonar_pkg;

    localparam int BCD_W    = 4;
    localparam int N_DIGITS = 3;
    localparam int MEDIDA_W = BCD_W * N_DIGITS;
    localparam int ESTADO_W = 3;

    localparam int CICLOS_TRIGGER_DEF = 500;
    localparam int CICLOS_POR_CM_DEF  = 2941;
    localparam int MAX_CM_DEF         = 400;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL       = 3'd0,
        PREPARACAO    = 3'd1,
        ENVIA_TRIGGER = 3'd2,
        ESPERA_ECHO   = 3'd3,
        MEDE          = 3'd4,
        ARMAZENA      = 3'd5,
        FINAL_MEDIDA  = 3'd6
    } estado_t;

    // Elaboration-time conversion of a centimetre constant to {hundreds, tens, units}.
    function automatic logic [MEDIDA_W-1:0] cm_para_bcd(input int cm);
        return {4'((cm / 100) % 10), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

endpackage

// File: rtl/contador_cm_bcd.sv
// rtl/contador_cm_bcd.sv - echo cycle divider, 3-digit BCD centimetre counter and saturation flag
module contador_cm_bcd
    import sonar_pkg::*;
#(
    parameter int CICLOS_POR_CM = CICLOS_POR_CM_DEF,
    parameter int MAX_CM        = MAX_CM_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                zera,
    input  logic                conta,
    output logic [MEDIDA_W-1:0] medida_bcd,
    output logic                saturado
);

    localparam int DIV_W = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;
    localparam logic [DIV_W-1:0]    DIV_ULTIMO = DIV_W'(CICLOS_POR_CM - 1);
    localparam logic [MEDIDA_W-1:0] MAX_BCD    = cm_para_bcd(MAX_CM);

    logic [DIV_W-1:0] divisor;
    logic [BCD_W-1:0] centenas, dezenas, unidades;

    assign medida_bcd = {centenas, dezenas, unidades};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divisor  <= '0;
            centenas <= '0;
            dezenas  <= '0;
            unidades <= '0;
            saturado <= 1'b0;
        end else if (zera) begin
            divisor  <= '0;
            centenas <= '0;
            dezenas  <= '0;
            unidades <= '0;
            saturado <= 1'b0;
        end else if (conta) begin
            if (divisor == DIV_ULTIMO) begin
                divisor <= '0;
                // A full centimetre beyond MAX_CM means the target is out of range.
                if (medida_bcd == MAX_BCD) begin
                    saturado <= 1'b1;
                end else if (unidades == 4'd9) begin
                    unidades <= '0;
                    if (dezenas == 4'd9) begin
                        dezenas  <= '0;
                        centenas <= centenas + 4'd1;
                    end else begin
                        dezenas <= dezenas + 4'd1;
                    end
                end else begin
                    unidades <= unidades + 4'd1;
                end
            end else begin
                divisor <= divisor + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sonar_medidor_hcsr04.sv
// rtl/sonar_medidor_hcsr04.sv - HC-SR04 trigger/echo timing FSM producing a BCD distance in cm
module sonar_medidor_hcsr04
    import sonar_pkg::*;
#(
    parameter int CICLOS_TRIGGER = CICLOS_TRIGGER_DEF,
    parameter int CICLOS_POR_CM  = CICLOS_POR_CM_DEF,
    parameter int MAX_CM         = MAX_CM_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                medir,
    input  logic                echo,
    output logic                trigger,
    output logic                pronto,
    output logic [MEDIDA_W-1:0] medida,
    output logic                fora_alcance,
    output logic [ESTADO_W-1:0] db_estado
);

    localparam int TIMER_W = $clog2(CICLOS_TRIGGER + 1);
    localparam logic [TIMER_W-1:0] TIMER_ULTIMO = TIMER_W'(CICLOS_TRIGGER - 1);

    estado_t estado, estado_prox;

    logic               echo_meta, echo_s, echo_d;
    logic               echo_sobe, echo_desce;
    logic [TIMER_W-1:0] timer;
    logic               zera, conta;
    logic [MEDIDA_W-1:0] medida_bcd;
    logic               saturado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign echo_sobe  = echo_s & ~echo_d;
    assign echo_desce = ~echo_s & echo_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        zera        = 1'b0;
        case (estado)
            INICIAL:       if (medir) estado_prox = PREPARACAO;
            PREPARACAO: begin
                zera        = 1'b1;
                estado_prox = ENVIA_TRIGGER;
            end
            ENVIA_TRIGGER: if (timer == TIMER_ULTIMO) estado_prox = ESPERA_ECHO;
            ESPERA_ECHO: begin
                if (medir)          estado_prox = PREPARACAO;
                else if (echo_sobe) estado_prox = MEDE;
            end
            MEDE: begin
                if (medir)           estado_prox = PREPARACAO;
                else if (echo_desce) estado_prox = ARMAZENA;
            end
            ARMAZENA:      estado_prox = FINAL_MEDIDA;
            FINAL_MEDIDA:  estado_prox = INICIAL;
            default:       estado_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (estado == PREPARACAO) begin
            timer <= '0;
        end else if (estado == ENVIA_TRIGGER) begin
            timer <= timer + 1'b1;
        end
    end

    // MEDE is entered and left on the same detect-register delay, so echo_d is
    // high for exactly the synchronised pulse width while in MEDE.
    assign conta = (estado == MEDE) && echo_d;

    contador_cm_bcd #(
        .CICLOS_POR_CM(CICLOS_POR_CM),
        .MAX_CM       (MAX_CM)
    ) u_contador (
        .clock     (clock),
        .reset     (reset),
        .zera      (zera),
        .conta     (conta),
        .medida_bcd(medida_bcd),
        .saturado  (saturado)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            medida       <= '0;
            fora_alcance <= 1'b0;
        end else if (estado == ARMAZENA) begin
            medida       <= medida_bcd;
            fora_alcance <= saturado;
        end
    end

    // Decoded from the state register only, so reset drops trigger immediately.
    assign trigger   = (estado == ENVIA_TRIGGER);
    assign pronto    = (estado == FINAL_MEDIDA);
    assign db_estado = estado;

endmodule

// File: tb/tb_sonar_medidor_hcsr04.sv
// tb/tb_sonar_medidor_hcsr04.sv - scoreboard bench for sonar_medidor_hcsr04 with scaled timing
module tb_sonar_medidor_hcsr04;
    import sonar_pkg::*;

    localparam int TRIG = 50;
    localparam int CPM  = 11;
    localparam int MAXC = 400;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        medir = 1'b0;
    logic        echo  = 1'b0;
    logic        trigger, pronto, fora_alcance;
    logic [11:0] medida;
    logic [2:0]  db_estado;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] esperado;

    always #5 clock = ~clock;

    sonar_medidor_hcsr04 #(
        .CICLOS_TRIGGER(TRIG),
        .CICLOS_POR_CM (CPM),
        .MAX_CM        (MAXC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .medir       (medir),
        .echo        (echo),
        .trigger     (trigger),
        .pronto      (pronto),
        .medida      (medida),
        .fora_alcance(fora_alcance),
        .db_estado   (db_estado)
    );

    function automatic logic [12:0] modelo(input int largura);
        int   cm;
        logic f;
        cm = largura / CPM;
        f  = 1'b0;
        if (cm > MAXC) begin
            cm = MAXC;
            f  = 1'b1;
        end
        return {f, 4'((cm / 100) % 10), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    always @(negedge clock) begin
        if (reset && pronto) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pronto_inesperado: pronto=1 with nothing pending, medida=%h fora=%b", medida, fora_alcance);
            end else begin
                esperado = exp_q.pop_front();
                if ({fora_alcance, medida} !== esperado) begin
                    errors++;
                    $display("FAIL resultado: got fora=%b medida=%h, expected fora=%b medida=%h",
                             fora_alcance, medida, esperado[12], esperado[11:0]);
                end
            end
        end
    end

    task automatic pulso_medir();
        @(negedge clock);
        medir = 1'b1;
        @(negedge clock);
        medir = 1'b0;
    endtask

    task automatic espera_estado(input logic [2:0] s, input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            if (db_estado == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic espera_pronto(input int limite, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limite; i++) begin
            @(negedge clock);
            if (pronto) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic conta_trigger(output int n);
        n = 0;
        for (int i = 0; i < TRIG * 4; i++) begin
            if (!trigger) break;
            n++;
            @(negedge clock);
        end
    endtask

    task automatic pulso_eco_e_pronto(input int largura, input string nome);
        bit ok;
        exp_q.push_back(modelo(largura));
        echo = 1'b1;
        repeat (largura) @(negedge clock);
        echo = 1'b0;
        espera_pronto(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_pronto: no pronto within 20 cycles, db_estado=%0d", nome, db_estado);
        end
        @(negedge clock);
        checks++;
        if (pronto !== 1'b0) begin
            errors++;
            $display("FAIL %s_pronto_largura: pronto=%b one cycle later, expected 0", nome, pronto);
        end
    endtask

    task automatic mede_eco(input int largura, input string nome);
        bit ok;
        pulso_medir();
        espera_estado(3'd3, TRIG + 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_espera_echo: db_estado=%0d, expected 3", nome, db_estado);
        end
        pulso_eco_e_pronto(largura, nome);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks += 5;
        if (trigger !== 1'b0) begin errors++; $display("FAIL reset_trigger: got %b expected 0", trigger); end
        if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
        if (medida !== 12'h000) begin errors++; $display("FAIL reset_medida: got %h expected 000", medida); end
        if (fora_alcance !== 1'b0) begin errors++; $display("FAIL reset_fora: got %b expected 0", fora_alcance); end
        if (db_estado !== 3'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_trigger();
        int n;
        pulso_medir();
        checks++;
        if (db_estado !== 3'd1) begin errors++; $display("FAIL trig_estado1: got %0d expected 1", db_estado); end
        @(negedge clock);
        checks += 2;
        if (db_estado !== 3'd2) begin errors++; $display("FAIL trig_estado2: got %0d expected 2", db_estado); end
        if (trigger !== 1'b1) begin errors++; $display("FAIL trig_alto: got %b expected 1", trigger); end
        conta_trigger(n);
        checks += 2;
        if (n != TRIG) begin errors++; $display("FAIL trig_largura: got %0d cycles expected %0d", n, TRIG); end
        if (db_estado !== 3'd3) begin errors++; $display("FAIL trig_estado3: got %0d expected 3", db_estado); end
        pulso_eco_e_pronto(20 * CPM, "20cm");
    endtask

    task automatic test_retry();
        bit          ok;
        int          n;
        logic [11:0] salvo;
        salvo = medida;
        pulso_medir();
        espera_estado(3'd3, TRIG + 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL retry_espera: db_estado=%0d expected 3", db_estado); end
        repeat (5) @(negedge clock);
        pulso_medir();
        checks++;
        if (db_estado !== 3'd1) begin errors++; $display("FAIL retry_prep: got %0d expected 1", db_estado); end
        @(negedge clock);
        conta_trigger(n);
        checks++;
        if (n != TRIG) begin errors++; $display("FAIL retry_trig_largura: got %0d expected %0d", n, TRIG); end
        repeat (30) @(negedge clock);
        checks += 2;
        if (medida !== salvo) begin errors++; $display("FAIL retry_medida: got %h expected %h", medida, salvo); end
        if (db_estado !== 3'd3) begin errors++; $display("FAIL retry_estado: got %0d expected 3", db_estado); end
    endtask

    task automatic test_eco_alto();
        bit ok;
        pulso_medir();
        @(negedge clock);
        echo = 1'b1;
        espera_estado(3'd3, TRIG + 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL eco_alto_espera: db_estado=%0d expected 3", db_estado); end
        repeat (20) @(negedge clock);
        checks++;
        if (db_estado !== 3'd3) begin errors++; $display("FAIL eco_alto_nivel: got %0d expected 3", db_estado); end
        echo = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (db_estado !== 3'd3) begin errors++; $display("FAIL eco_alto_queda: got %0d expected 3", db_estado); end
        pulso_eco_e_pronto(20 * CPM, "eco_alto");
    endtask

    task automatic test_reset_assincrono();
        bit ok;
        pulso_medir();
        espera_estado(3'd3, TRIG + 10, ok);
        echo = 1'b1;
        repeat (100) @(negedge clock);
        checks++;
        if (db_estado !== 3'd4) begin errors++; $display("FAIL rst_mede_estado: got %0d expected 4", db_estado); end
        #2 reset = 1'b0;
        #1;
        checks += 3;
        if (medida !== 12'h000) begin errors++; $display("FAIL rst_mede_medida: got %h expected 000", medida); end
        if (db_estado !== 3'd0) begin errors++; $display("FAIL rst_mede_db: got %0d expected 0", db_estado); end
        if (pronto !== 1'b0) begin errors++; $display("FAIL rst_mede_pronto: got %b expected 0", pronto); end
        echo = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        pulso_medir();
        @(negedge clock);
        checks++;
        if (trigger !== 1'b1) begin errors++; $display("FAIL rst_trig_alto: got %b expected 1", trigger); end
        #2 reset = 1'b0;
        #1;
        checks += 2;
        if (trigger !== 1'b0) begin errors++; $display("FAIL rst_trig_baixo: got %b expected 0", trigger); end
        if (db_estado !== 3'd0) begin errors++; $display("FAIL rst_trig_db: got %0d expected 0", db_estado); end
        @(negedge clock);
        reset = 1'b1;
        mede_eco(123 * CPM, "limpa_123cm");
    endtask

    initial begin
        test_reset();
        test_trigger();
        mede_eco(10 * CPM, "10cm");
        mede_eco(CPM - 1, "abaixo_1cm");
        mede_eco(123 * CPM, "123cm");
        mede_eco(5000, "saturado");
        mede_eco(20 * CPM, "apos_saturado");
        test_retry();
        test_eco_alto();
        test_reset_assincrono();
        repeat (5) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_vazio: %0d results pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
